// File: rtl/f_fetch_unit_pkg.sv
// Shared CPU package for the fetch stage.
// Holds the default fetch address / legal instruction range, the 2-bit
// fetch FSM encoding, the NOP word, the {instr, err} word carried through
// the hold buffer, and the fetch-address legality check.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_LO_DEF    = 32'h0000_3000;
    localparam logic [31:0] PC_HI_DEF    = 32'h0000_6FFC;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    // Legacy state encodings, kept so older debug scripts still decode them
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        F_IDLE = ST_IDLE,
        F_REQ  = ST_REQ,
        F_WAIT = ST_WAIT,
        F_HOLD = ST_HOLD
    } f_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } fetch_word_t;

    // Word aligned and inside [lo, hi]
    function automatic logic pc_legal(input logic [31:0] pc,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
    endfunction

endpackage

// File: rtl/f_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit and memory.
//   req_valid / req_ready / req_addr : read request handshake
//   rsp_valid / rsp_data             : read response (no backpressure)
// master: fetch unit side, slave: memory side.
interface f_fetch_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/f_fetch_unit_hold_buf.sv
// f_hold_buf: one-entry buffer that parks a fetched {instr, err} while the
// decode stage is stalled.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture d, mark valid
//   clear        : drop the entry (wins over load)
//   d / q        : word in / held word out
//   valid        : entry is occupied
module f_hold_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        clear,
    input  fetch_word_t d,
    output fetch_word_t q,
    output logic        valid
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// f_fetch_unit: fetch stage of the 5-stage MIPS pipeline.
// Holds F_PC, issues one outstanding instruction-memory read at a time,
// loads the F/D register or parks the word in a hold buffer while D stalls.
//   clk, reset_n : clock, asynchronous active-low reset
//   NPC          : next fetch address from D-stage next-PC logic
//   stall, flush : D backpressure / redirect (flush has priority)
//   F_PC         : current fetch PC (fed back to next-PC logic)
//   imem         : instruction-memory request/response channel (master)
//   D_PC, D_Instr, D_valid, D_excAdEL : F/D pipeline register
module f_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] PC_LO    = PC_LO_DEF,
    parameter logic [31:0] PC_HI    = PC_HI_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           NPC,
    input  logic                  stall,
    input  logic                  flush,
    output logic [31:0]           F_PC,
    f_fetch_unit_if.master        imem,
    output logic [31:0]           D_PC,
    output logic [31:0]           D_Instr,
    output logic                  D_valid,
    output logic                  D_excAdEL
);

    f_state_e    state, state_nx;
    logic        kill, kill_nx;
    logic [31:0] f_pc_nx;
    logic        pc_ok;

    // Fetch result this cycle: a real response in WAIT, or a synthesized
    // AdEL "response" in REQ when the PC is illegal (no bus transaction).
    logic        res_valid;
    fetch_word_t res_word;

    logic        fd_load;
    logic        discard;
    logic        hb_load, hb_clear, hb_valid;
    fetch_word_t hb_q;
    fetch_word_t fd_word;

    assign pc_ok          = pc_legal(F_PC, PC_LO, PC_HI);
    assign imem.req_valid = (state == F_REQ) && pc_ok;
    assign imem.req_addr  = F_PC;

    always_comb begin
        res_valid      = 1'b0;
        res_word.instr = NOP;
        res_word.err   = 1'b0;
        if (state == F_WAIT && imem.rsp_valid) begin
            res_valid      = 1'b1;
            res_word.instr = imem.rsp_data;
        end else if (state == F_REQ && !pc_ok) begin
            res_valid    = 1'b1;
            res_word.err = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        f_pc_nx  = F_PC;
        kill_nx  = kill;
        fd_load  = 1'b0;
        discard  = 1'b0;
        hb_load  = 1'b0;
        hb_clear = 1'b0;
        if (res_valid) begin
            state_nx = F_REQ;
            if (flush || kill) begin
                discard = 1'b1;
                kill_nx = 1'b0;
                f_pc_nx = NPC;
            end else if (!stall) begin
                fd_load = 1'b1;
                f_pc_nx = NPC;
            end else begin
                hb_load  = 1'b1;
                state_nx = F_HOLD;
            end
        end else begin
            case (state)
                F_IDLE: state_nx = F_REQ;
                F_REQ: begin
                    // Request must stay stable until accepted, so a flush
                    // here is deferred: the eventual response gets killed.
                    if (flush) kill_nx = 1'b1;
                    if (imem.req_ready) state_nx = F_WAIT;
                end
                F_WAIT: begin
                    if (flush) kill_nx = 1'b1;
                end
                F_HOLD: begin
                    if (flush) begin
                        hb_clear = 1'b1;
                        f_pc_nx  = NPC;
                        state_nx = F_REQ;
                    end else if (!stall) begin
                        fd_load  = 1'b1;
                        hb_clear = 1'b1;
                        f_pc_nx  = NPC;
                        state_nx = F_REQ;
                    end
                end
                default: state_nx = F_IDLE;
            endcase
        end
    end

    // Buffer is only occupied in HOLD, so its valid selects the F/D source
    assign fd_word = hb_valid ? hb_q : res_word;

    f_hold_buf u_hold_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (hb_load),
        .clear   (hb_clear),
        .d       (res_word),
        .q       (hb_q),
        .valid   (hb_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= F_IDLE;
            F_PC  <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_nx;
            F_PC  <= f_pc_nx;
            kill  <= kill_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            D_PC      <= '0;
            D_Instr   <= NOP;
            D_valid   <= 1'b0;
            D_excAdEL <= 1'b0;
        end else if (fd_load) begin
            D_PC      <= F_PC;
            D_Instr   <= fd_word.instr;
            D_valid   <= 1'b1;
            D_excAdEL <= fd_word.err;
        end else if (flush) begin
            D_valid   <= 1'b0;
            D_Instr   <= NOP;
            D_excAdEL <= 1'b0;
        end else if (stall) begin
            if (discard) D_valid <= 1'b0;
        end else begin
            D_valid <= 1'b0;
            D_Instr <= NOP;
        end
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
module tb_f_fetch_unit;

    localparam logic [31:0] LO = 32'h0000_3000;
    localparam logic [31:0] HI = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] npc = 32'h0000_3004;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] F_PC, D_PC, D_Instr;
    logic        D_valid, D_excAdEL;

    int n_vec = 0;
    int n_err = 0;

    f_fetch_unit_if imem ();

    f_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .PC_LO    (LO),
        .PC_HI    (HI)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .NPC       (npc),
        .stall     (stall),
        .flush     (flush),
        .F_PC      (F_PC),
        .imem      (imem.master),
        .D_PC      (D_PC),
        .D_Instr   (D_Instr),
        .D_valid   (D_valid),
        .D_excAdEL (D_excAdEL)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= LO) && (a <= HI);
    endfunction

    // ---------------- memory responder ----------------
    int unsigned lat = 1;
    logic        ready = 1'b1;
    logic        mem_ol = 1'b0;
    int unsigned mem_rem = 0;
    logic [31:0] mem_addr = '0;

    assign imem.req_ready = ready;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ol = 1'b0;
        end else begin
            if (imem.rsp_valid) mem_ol = 1'b0;
            if (mem_ol && mem_rem > 1) mem_rem = mem_rem - 1;
            if (imem.req_valid && imem.req_ready) begin
                mem_ol   = 1'b1;
                mem_rem  = lat;
                mem_addr = imem.req_addr;
            end
        end
    end

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem.rsp_valid = 1'b0;
            imem.rsp_data  = 32'hBAD0_BAD0;
        end else if (mem_ol && mem_rem == 1) begin
            imem.rsp_valid = 1'b1;
            imem.rsp_data  = mem_word(mem_addr);
        end else begin
            imem.rsp_valid = 1'b0;
            imem.rsp_data  = 32'hBAD0_BAD0;
        end
    end

    // ---------------- transaction-level model ----------------
    logic        m_started, m_pend, m_kill, m_held, m_hold_err;
    logic [31:0] m_hold_instr, m_fpc, m_dpc, m_dinstr;
    logic        m_dvalid, m_dexc;
    logic        m_got, m_gerr, m_loaded, m_dropped;
    logic [31:0] m_gdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_started = 1'b0; m_pend = 1'b0; m_kill = 1'b0; m_held = 1'b0;
            m_hold_err = 1'b0; m_hold_instr = '0;
            m_fpc = 32'h0000_3000; m_dpc = '0; m_dinstr = '0;
            m_dvalid = 1'b0; m_dexc = 1'b0;
        end else begin
            m_got = 1'b0; m_gerr = 1'b0; m_gdata = '0; m_loaded = 1'b0; m_dropped = 1'b0;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_held) begin
                if (flush) begin
                    m_held = 1'b0;
                    m_fpc  = npc;
                end else if (!stall) begin
                    m_dpc = m_fpc; m_dinstr = m_hold_instr; m_dexc = m_hold_err;
                    m_dvalid = 1'b1; m_loaded = 1'b1;
                    m_held = 1'b0;
                    m_fpc  = npc;
                end
            end else if (m_pend) begin
                if (imem.rsp_valid) begin
                    m_pend = 1'b0; m_got = 1'b1; m_gdata = imem.rsp_data;
                end else if (flush) begin
                    m_kill = 1'b1;
                end
            end else if (!legal(m_fpc)) begin
                m_got = 1'b1; m_gerr = 1'b1;
            end else begin
                if (flush) m_kill = 1'b1;
                if (ready) m_pend = 1'b1;
            end
            if (m_got) begin
                if (flush || m_kill) begin
                    m_kill = 1'b0; m_fpc = npc; m_dropped = 1'b1;
                end else if (!stall) begin
                    m_dpc = m_fpc; m_dinstr = m_gdata; m_dexc = m_gerr;
                    m_dvalid = 1'b1; m_loaded = 1'b1;
                    m_fpc = npc;
                end else begin
                    m_held = 1'b1; m_hold_instr = m_gdata; m_hold_err = m_gerr;
                end
            end
            if (!m_loaded) begin
                if (flush) begin
                    m_dvalid = 1'b0; m_dinstr = '0; m_dexc = 1'b0;
                end else if (stall) begin
                    if (m_dropped) m_dvalid = 1'b0;
                end else begin
                    m_dvalid = 1'b0; m_dinstr = '0;
                end
            end
        end
    end

    // NPC source: follows the model PC (+4) unless a fixed target is forced
    logic        npc_fixed_en = 1'b0;
    logic [31:0] npc_fixed = '0;

    always @(posedge clk) begin
        #2;
        npc = npc_fixed_en ? npc_fixed : m_fpc + 32'd4;
    end

    // ---------------- per-cycle compare ----------------
    logic exp_rv;

    always @(posedge clk) begin
        #1;
        exp_rv = m_started && !m_pend && !m_held && legal(m_fpc);
        chk("F_PC", F_PC, m_fpc);
        chk("req_valid", {31'd0, imem.req_valid}, {31'd0, exp_rv});
        if (exp_rv) chk("req_addr", imem.req_addr, m_fpc);
        chk("D_PC", D_PC, m_dpc);
        chk("D_Instr", D_Instr, m_dinstr);
        chk("D_valid", {31'd0, D_valid}, {31'd0, m_dvalid});
        chk("D_excAdEL", {31'd0, D_excAdEL}, {31'd0, m_dexc});
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the releasing negedge; cyc(k) then lands mid cycle k
    task automatic do_reset(input int unsigned l);
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0; npc_fixed_en = 1'b0;
        lat = l; ready = 1'b1;
        cyc(2);
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: streaming, latency 1
        do_reset(1);
        cyc(1);
        chk("s1 c1 req_valid", {31'd0, imem.req_valid}, 32'd1);
        chk("s1 c1 req_addr", imem.req_addr, 32'h0000_3000);
        cyc(1);
        chk("s1 c2 req_valid", {31'd0, imem.req_valid}, 32'd0);
        cyc(1);
        chk("s1 c3 D_valid", {31'd0, D_valid}, 32'd1);
        chk("s1 c3 D_PC", D_PC, 32'h0000_3000);
        chk("s1 c3 D_Instr", D_Instr, 32'hCFFF_3000);
        chk("s1 c3 F_PC", F_PC, 32'h0000_3004);
        cyc(1);
        chk("s1 c4 D_valid", {31'd0, D_valid}, 32'd0);
        cyc(1);
        chk("s1 c5 D_PC", D_PC, 32'h0000_3004);
        chk("s1 c5 D_valid", {31'd0, D_valid}, 32'd1);
        cyc(1);
        chk("s1 c6 D_valid", {31'd0, D_valid}, 32'd0);
        cyc(1);
        chk("s1 c7 D_PC", D_PC, 32'h0000_3008);

        // 2: stall when response for 0x3004 arrives
        do_reset(1);
        cyc(3);
        stall = 1'b1;
        cyc(2);
        chk("s2 c5 F_PC", F_PC, 32'h0000_3004);
        chk("s2 c5 D_PC", D_PC, 32'h0000_3000);
        chk("s2 c5 D_valid", {31'd0, D_valid}, 32'd1);
        chk("s2 c5 req_valid", {31'd0, imem.req_valid}, 32'd0);
        cyc(1);
        chk("s2 c6 F_PC", F_PC, 32'h0000_3004);
        stall = 1'b0;
        cyc(1);
        chk("s2 c7 D_PC", D_PC, 32'h0000_3004);
        chk("s2 c7 D_Instr", D_Instr, 32'hCFFB_3004);
        chk("s2 c7 req_addr", imem.req_addr, 32'h0000_3008);
        chk("s2 c7 req_valid", {31'd0, imem.req_valid}, 32'd1);

        // 3: flush during WAIT, response 2 cycles after acceptance
        do_reset(2);
        cyc(2);
        npc_fixed = 32'h0000_3400; npc_fixed_en = 1'b1; flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(1);
        chk("s3 c4 D_valid", {31'd0, D_valid}, 32'd0);
        chk("s3 c4 req_addr", imem.req_addr, 32'h0000_3400);
        chk("s3 c4 req_valid", {31'd0, imem.req_valid}, 32'd1);
        npc_fixed_en = 1'b0;
        cyc(3);
        chk("s3 c7 D_PC", D_PC, 32'h0000_3400);
        chk("s3 c7 D_Instr", D_Instr, 32'hCBFF_3400);

        // 4: flush and stall together in HOLD
        do_reset(1);
        cyc(3);
        stall = 1'b1;
        cyc(1);
        npc_fixed = 32'h0000_3800; npc_fixed_en = 1'b1;
        cyc(1);
        chk("s4 c5 F_PC", F_PC, 32'h0000_3004);
        flush = 1'b1;
        cyc(1);
        chk("s4 c6 F_PC", F_PC, 32'h0000_3800);
        chk("s4 c6 D_valid", {31'd0, D_valid}, 32'd0);
        chk("s4 c6 D_Instr", D_Instr, 32'h0);
        chk("s4 c6 req_valid", {31'd0, imem.req_valid}, 32'd1);
        flush = 1'b0; stall = 1'b0; npc_fixed_en = 1'b0;
        cyc(2);
        chk("s4 c8 D_PC", D_PC, 32'h0000_3800);
        chk("s4 c8 D_Instr", D_Instr, 32'hC7FF_3800);

        // 5: misaligned then out-of-range fetch addresses
        do_reset(1);
        npc_fixed = 32'h0000_3002; npc_fixed_en = 1'b1;
        cyc(2);
        npc_fixed = 32'h0000_7000;
        cyc(1);
        chk("s5 c3 F_PC", F_PC, 32'h0000_3002);
        chk("s5 c3 req_valid", {31'd0, imem.req_valid}, 32'd0);
        npc_fixed = 32'h0000_3100;
        cyc(1);
        chk("s5 c4 D_PC", D_PC, 32'h0000_3002);
        chk("s5 c4 D_Instr", D_Instr, 32'h0);
        chk("s5 c4 D_excAdEL", {31'd0, D_excAdEL}, 32'd1);
        chk("s5 c4 req_valid", {31'd0, imem.req_valid}, 32'd0);
        chk("s5 c4 F_PC", F_PC, 32'h0000_7000);
        cyc(1);
        chk("s5 c5 D_PC", D_PC, 32'h0000_7000);
        chk("s5 c5 D_excAdEL", {31'd0, D_excAdEL}, 32'd1);
        chk("s5 c5 req_addr", imem.req_addr, 32'h0000_3100);
        npc_fixed_en = 1'b0;

        // 6: asynchronous reset while in WAIT
        do_reset(2);
        cyc(5);
        chk("s6 c5 F_PC", F_PC, 32'h0000_3004);
        reset_n = 1'b0;
        #1;
        chk("s6 rst F_PC", F_PC, 32'h0000_3000);
        chk("s6 rst D_PC", D_PC, 32'h0);
        chk("s6 rst D_valid", {31'd0, D_valid}, 32'd0);
        chk("s6 rst D_Instr", D_Instr, 32'h0);
        chk("s6 rst req_valid", {31'd0, imem.req_valid}, 32'd0);
        lat = 1;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        chk("s6 c1 req_addr", imem.req_addr, 32'h0000_3000);
        chk("s6 c1 req_valid", {31'd0, imem.req_valid}, 32'd1);
        cyc(2);
        chk("s6 c3 D_PC", D_PC, 32'h0000_3000);
        chk("s6 c3 D_valid", {31'd0, D_valid}, 32'd1);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
